// File: rtl/pifo_tb_pkg.sv
// Shared types and constants for the PIFO push-stream traffic generator.
package pifo_tb_pkg;

    typedef enum logic [1:0] {
        RANK_INC   = 2'b00,
        RANK_DEC   = 2'b01,
        RANK_LFSR  = 2'b10,
        RANK_CONST = 2'b11
    } rank_mode_t;

    typedef enum logic [1:0] {
        TG_IDLE = 2'b00,
        TG_SEND = 2'b01,
        TG_GAP  = 2'b10
    } tg_state_t;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/pifo_traffic_generator_if.sv
// Valid/ready push channel carrying a PIFO rank and its metadata.
interface pifo_traffic_generator_if #(
    parameter int unsigned RANK_WIDTH = 16,
    parameter int unsigned META_WIDTH = 16
);

    logic                  out_valid;
    logic                  out_ready;
    logic [RANK_WIDTH-1:0] out_rank;
    logic [META_WIDTH-1:0] out_meta;

    modport master (
        output out_valid,
        output out_rank,
        output out_meta,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_rank,
        input  out_meta,
        output out_ready
    );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 0,2,3,5) that advances once per step pulse.
module lfsr16
    import pifo_tb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic        fb;

    assign fb    = value_q[0] ^ value_q[2] ^ value_q[3] ^ value_q[5];
    assign value = value_q;

    // An all-zero seed would lock the register up, so it falls back to the default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        end else if (step) begin
            value_q <= {fb, value_q[15:1]};
        end
    end

endmodule

// File: rtl/pifo_traffic_generator.sv
// Programmable PIFO push-request source: rank patterns, inter-arrival gaps,
// abort, and per-run progress/stall counters.
module pifo_traffic_generator
    import pifo_tb_pkg::*;
#(
    parameter int unsigned RANK_WIDTH  = 16,
    parameter int unsigned META_WIDTH  = 16,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [COUNT_WIDTH-1:0] num_pkts,
    input  logic [COUNT_WIDTH-1:0] gap_cycles,
    input  logic [1:0]             rank_mode,
    input  logic [RANK_WIDTH-1:0]  rank_base,
    pifo_traffic_generator_if.master push,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] sent_count,
    output logic [COUNT_WIDTH-1:0] stall_cycles
);

    tg_state_t              state_q;
    rank_mode_t             mode_q;
    logic [COUNT_WIDTH-1:0] num_q;
    logic [COUNT_WIDTH-1:0] gap_len_q;
    logic [COUNT_WIDTH-1:0] gap_cnt_q;
    logic [COUNT_WIDTH-1:0] sent_q;
    logic [COUNT_WIDTH-1:0] stall_q;
    logic [RANK_WIDTH-1:0]  rank_q;
    logic [META_WIDTH-1:0]  meta_q;
    logic                   valid_q;
    logic                   done_q;

    logic        accept;
    logic        last_beat;
    logic        lfsr_step;
    logic [15:0] lfsr_value;

    assign accept    = valid_q & push.out_ready;
    assign last_beat = (sent_q + COUNT_WIDTH'(1)) == num_q;
    assign lfsr_step = accept && (state_q == TG_SEND) && (mode_q == RANK_LFSR);

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    // In LFSR mode the rank is the live LFSR register, so it already holds the
    // stepped value on the cycle after an accept.
    assign push.out_rank  = ((mode_q == RANK_LFSR) && (state_q != TG_IDLE)) ?
                            lfsr_value[RANK_WIDTH-1:0] : rank_q;
    assign push.out_valid = valid_q;
    assign push.out_meta  = meta_q;
    assign busy           = (state_q != TG_IDLE);
    assign done           = done_q;
    assign sent_count     = sent_q;
    assign stall_cycles   = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TG_IDLE;
            mode_q    <= RANK_INC;
            num_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            sent_q    <= '0;
            stall_q   <= '0;
            rank_q    <= '0;
            meta_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                TG_IDLE: begin
                    if (start) begin
                        num_q     <= num_pkts;
                        gap_len_q <= gap_cycles;
                        mode_q    <= rank_mode_t'(rank_mode);
                        rank_q    <= rank_base;
                        meta_q    <= '0;
                        sent_q    <= '0;
                        stall_q   <= '0;
                        if (num_pkts == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            done_q  <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= TG_SEND;
                        end
                    end
                end
                TG_SEND: begin
                    if (!push.out_ready) begin
                        if (stall_q != '1) begin
                            stall_q <= stall_q + COUNT_WIDTH'(1);
                        end
                    end else begin
                        sent_q <= sent_q + COUNT_WIDTH'(1);
                        meta_q <= meta_q + META_WIDTH'(1);
                        unique case (mode_q)
                            RANK_INC:   rank_q <= rank_q + RANK_WIDTH'(1);
                            RANK_DEC:   rank_q <= rank_q - RANK_WIDTH'(1);
                            RANK_LFSR:  rank_q <= rank_q;
                            RANK_CONST: rank_q <= rank_q;
                            default:    rank_q <= rank_q;
                        endcase
                        if (last_beat || stop) begin
                            state_q <= TG_IDLE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (gap_len_q != '0) begin
                            state_q   <= TG_GAP;
                            valid_q   <= 1'b0;
                            gap_cnt_q <= gap_len_q;
                        end
                    end
                end
                TG_GAP: begin
                    if (stop) begin
                        state_q <= TG_IDLE;
                        done_q  <= 1'b1;
                    end else if (gap_cnt_q == COUNT_WIDTH'(1)) begin
                        state_q <= TG_SEND;
                        valid_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= TG_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pifo_traffic_generator.sv
// Directed self-checking bench: expected beats are queued at start and
// compared against every accepted push.
module tb_pifo_traffic_generator;

    typedef struct {
        logic [15:0] rank;
        logic [15:0] meta;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] num_pkts;
    logic [15:0] gap_cycles;
    logic [1:0]  rank_mode;
    logic [15:0] rank_base;
    logic        busy;
    logic        done;
    logic [15:0] sent_count;
    logic [15:0] stall_cycles;

    int    vectors;
    int    miscompares;
    int    cyc;
    int    valid_cycles;
    int    s;
    beat_t sb[$];
    int    acc_cyc[$];

    pifo_traffic_generator_if #(.RANK_WIDTH(16), .META_WIDTH(16)) push_if ();

    pifo_traffic_generator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .num_pkts     (num_pkts),
        .gap_cycles   (gap_cycles),
        .rank_mode    (rank_mode),
        .rank_base    (rank_base),
        .push         (push_if),
        .busy         (busy),
        .done         (done),
        .sent_count   (sent_count),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (push_if.out_valid === 1'b1) valid_cycles++;
        if (push_if.out_valid === 1'b1 && push_if.out_ready === 1'b1) begin
            acc_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_rank", 32'(push_if.out_rank), 32'(e.rank));
                check("beat_meta", 32'(push_if.out_meta), 32'(e.meta));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n, input logic [15:0] g,
                            input logic [1:0] m, input logic [15:0] b);
        num_pkts   = n;
        gap_cycles = g;
        rank_mode  = m;
        rank_base  = b;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        s          = cyc;
    endtask

    task automatic push_exp(input logic [15:0] r, input logic [15:0] m);
        beat_t e;
        e.rank = r;
        e.meta = m;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) break;
            tick();
        end
        check("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, 32'(push_if.out_valid), 32'd0);
        check({tag, "_rank"},  32'(push_if.out_rank),  32'd0);
        check({tag, "_meta"},  32'(push_if.out_meta),  32'd0);
        check({tag, "_busy"},  32'(busy),              32'd0);
        check({tag, "_done"},  32'(done),              32'd0);
        check({tag, "_sent"},  32'(sent_count),        32'd0);
        check({tag, "_stall"}, 32'(stall_cycles),      32'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; valid_cycles = 0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        num_pkts = '0; gap_cycles = '0; rank_mode = 2'b00; rank_base = '0;
        push_if.out_ready = 1'b1;
        tick(); tick();
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: increment, back-to-back
        push_exp(16'd5, 16'd0); push_exp(16'd6, 16'd1);
        push_exp(16'd7, 16'd2); push_exp(16'd8, 16'd3);
        acc_cyc.delete();
        do_start(16'd4, 16'd0, 2'b00, 16'd5);
        wait_done(20);
        check("t1_accepts", 32'(acc_cyc.size()), 32'd4);
        if (acc_cyc.size() == 4) begin
            check("t1_first_latency", 32'(acc_cyc[0]), 32'(s));
            check("t1_back_to_back", 32'(acc_cyc[3]), 32'(s + 3));
        end
        check("t1_sent", 32'(sent_count), 32'd4);
        check("t1_stall", 32'(stall_cycles), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);

        // 2: LFSR ranks from the default seed
        push_exp(16'hACE1, 16'd0); push_exp(16'h5670, 16'd1); push_exp(16'hAB38, 16'd2);
        do_start(16'd3, 16'd0, 2'b10, 16'h0000);
        wait_done(20);
        check("t2_sent", 32'(sent_count), 32'd3);

        // 3: decrement with wrap and a gap of 2
        push_exp(16'd1, 16'd0); push_exp(16'd0, 16'd1); push_exp(16'hFFFF, 16'd2);
        acc_cyc.delete();
        do_start(16'd3, 16'd2, 2'b01, 16'd1);
        wait_done(30);
        check("t3_accepts", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            check("t3_gap_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("t3_run_length", 32'(acc_cyc[2] - s + 1), 32'd7);
        end

        // 4: backpressure on beat 0
        push_if.out_ready = 1'b0;
        push_exp(16'd10, 16'd0); push_exp(16'd11, 16'd1);
        do_start(16'd2, 16'd0, 2'b00, 16'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(push_if.out_valid), 32'd1);
            check("t4_hold_rank", 32'(push_if.out_rank), 32'd10);
            check("t4_hold_meta", 32'(push_if.out_meta), 32'd0);
            tick();
        end
        push_if.out_ready = 1'b1;
        wait_done(20);
        check("t4_stall", 32'(stall_cycles), 32'd3);
        check("t4_sent", 32'(sent_count), 32'd2);

        // 5a: zero-length run
        valid_cycles = 0;
        do_start(16'd0, 16'd0, 2'b00, 16'd3);
        check("t5a_done", 32'(done), 32'd1);
        check("t5a_busy", 32'(busy), 32'd0);
        tick(); tick(); tick();
        check("t5a_no_valid", 32'(valid_cycles), 32'd0);

        // 5b: start while busy is ignored
        push_exp(16'd7, 16'd0); push_exp(16'd7, 16'd1); push_exp(16'd7, 16'd2);
        do_start(16'd3, 16'd1, 2'b11, 16'd7);
        tick();
        do_start(16'd10, 16'd0, 2'b00, 16'd99);
        wait_done(30);
        tick(); tick();
        check("t5b_sent", 32'(sent_count), 32'd3);
        check("t5b_busy", 32'(busy), 32'd0);

        // 5c: stop during the gap after the first beat
        push_exp(16'd0, 16'd0);
        do_start(16'd10, 16'd5, 2'b00, 16'd0);
        tick();
        check("t5c_in_gap", 32'(push_if.out_valid), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5c_done", 32'(done), 32'd1);
        check("t5c_sent", 32'(sent_count), 32'd1);
        check("t5c_busy", 32'(busy), 32'd0);

        // 6: asynchronous reset mid-SEND while stalled
        push_if.out_ready = 1'b0;
        do_start(16'd5, 16'd0, 2'b00, 16'd3);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        push_if.out_ready = 1'b1;
        tick();
        push_exp(16'd20, 16'd0); push_exp(16'd21, 16'd1);
        do_start(16'd2, 16'd0, 2'b00, 16'd20);
        wait_done(20);
        check("t6_sent", 32'(sent_count), 32'd2);

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pifo_traffic_generator.md
Name: pifo_traffic_generator

Overview:
Testbench-support stimulus source that runs off the bench clock and produces a programmable stream of PIFO push requests (rank + metadata) over a valid/ready interface. It sits between the bench clock generator and the PIFO DUT's push port. It replaces ad-hoc initial-block stimulus with a cycle-accurate, reproducible generator. It supports incrementing, decrementing, constant and LFSR rank patterns, inter-arrival gaps, abort, and progress/stall counters.

Parameters:
RANK_WIDTH, 16, width of out_rank; legal range 1..16.
META_WIDTH, 16, width of out_meta, which carries the sequence number.
COUNT_WIDTH, 16, width of num_pkts, gap_cycles, sent_count and stall_cycles.
LFSR_SEED, 16'hACE1, LFSR reset/start value; 0 is replaced by 16'hACE1.

Ports:
clk  input  1  bench clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  1-cycle pulse; latches config and begins a run; ignored while busy.
stop  input  1  synchronous abort request; level or pulse.
num_pkts  input  COUNT_WIDTH  number of pushes per run.
gap_cycles  input  COUNT_WIDTH  idle cycles inserted after each accepted push.
rank_mode  input  2  00 increment, 01 decrement, 10 LFSR, 11 constant.
rank_base  input  RANK_WIDTH  first rank (modes 00/01/11).
out_valid  output  1  push request valid.
out_ready  input  1  DUT accepts when high together with out_valid.
out_rank  output  RANK_WIDTH  push rank.
out_meta  output  META_WIDTH  sequence number, 0-based per run.
busy  output  1  high in SEND or GAP.
done  output  1  sticky completion flag; cleared by start.
sent_count  output  COUNT_WIDTH  accepted pushes this run.
stall_cycles  output  COUNT_WIDTH  cycles with out_valid & !out_ready this run; saturating.

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE.
  - out_valid=0, out_rank=0, out_meta=0, busy=0, done=0, sent_count=0, stall_cycles=0.
  - LFSR is set to LFSR_SEED.
  - Reset may assert at any point mid-run; the run is lost and no beat is completed.
- States: IDLE, SEND, GAP. Accept = out_valid & out_ready sampled at a rising clk edge.
- IDLE, on start:
  - Latch num_pkts, gap_cycles, rank_mode and rank_base.
  - Clear done, sent_count and stall_cycles; set out_meta=0.
  - If num_pkts==0: stay IDLE and set done=1 on that same edge; out_valid never asserts.
  - Otherwise go to SEND; out_valid=1 from the cycle after the start edge (latency 1).
  - First out_rank: rank_base for modes 00/01/11; LFSR[RANK_WIDTH-1:0] for mode 10.
- SEND:
  - out_valid=1. Rank and meta are held stable until accept; valid never drops without accept.
  - Each cycle with out_valid & !out_ready increments stall_cycles, saturating at all-ones.
  - On accept: sent_count+1, out_meta+1, and the rank advances:
    - 00: +1, wrapping modulo 2^RANK_WIDTH.
    - 01: -1, wrapping.
    - 11: unchanged.
    - 10: LFSR steps once, then out_rank = new LFSR[RANK_WIDTH-1:0].
  - LFSR step: fb = l[0]^l[2]^l[3]^l[5]; l = {fb, l[15:1]}. The LFSR is not reloaded between runs.
  - If the accepted beat was beat num_pkts, or stop is high at the accept edge: go to IDLE, out_valid=0, done=1.
  - Else if gap_cycles==0: stay in SEND (back-to-back, valid stays high).
  - Else: go to GAP with out_valid=0 and load gap counter = gap_cycles.
- GAP:
  - out_valid=0; the counter decrements each cycle.
  - When counter==1, return to SEND, so exactly gap_cycles low cycles occur.
  - stop high in GAP: go to IDLE and set done=1 next edge.
- stop in SEND without accept takes no effect until accept (handshake integrity).
- stop in IDLE is ignored.
- start and stop together in IDLE: start wins. start while busy: ignored.
- out_meta wraps modulo 2^META_WIDTH. sent_count does not saturate, because it cannot exceed num_pkts.
- busy = (state != IDLE).

Decomposition:
- Package pifo_tb_pkg holds:
  - enum rank_mode_t {RANK_INC, RANK_DEC, RANK_LFSR, RANK_CONST}.
  - enum tg_state_t {TG_IDLE, TG_SEND, TG_GAP}.
  - localparam LFSR_DEFAULT_SEED = 16'hACE1.
- Sub-module lfsr16 (clk, rst_n, seed, step, value) isolates the polynomial; all other logic stays in the top module.

Test Plan:
1. rank_mode=00, rank_base=5, num_pkts=4, gap=0, out_ready=1 -> valid high for 4 consecutive cycles starting 1 cycle after start; ranks 5,6,7,8; meta 0..3; done=1, sent_count=4, stall_cycles=0.
2. rank_mode=10, seed ACE1, num_pkts=3, ready=1 -> ranks ACE1, 5670, AB38.
3. rank_mode=01, rank_base=1, num_pkts=3, gap=2, ready=1 -> ranks 1, 0, FFFF; exactly 2 low-valid cycles between beats; total run 7 cycles.
4. num_pkts=2, ready low for 3 cycles on beat 0 -> rank/meta held stable while stalled; stall_cycles=3; both beats accepted.
5. Corner cases:
   - num_pkts=0: done=1 with no valid.
   - start during run: ignored.
   - stop during GAP after beat 1 of 10: done=1, sent_count=1.
6. rst_n low mid-SEND with ready=0 -> all outputs zero immediately (async); new start restarts with meta=0.
